bench_scoreboard: RTL and testbench
===================================

BENCH_SCOREBOARD -- requirements
Module: bench_scoreboard

Interface
REQ-001 SHALL provide parameter NUM_COND, default 4, number of benchmark conditions (legal 2..8).
REQ-002 SHALL provide parameter CNT_W, default 32, cycle-counter and stored-count width.
REQ-003 SHALL provide parameter TIMEOUT, default 1048576, per-condition cycle limit; elaboration SHALL fail if TIMEOUT >= 2^CNT_W.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_btn  input  1  run request, already synchronised and debounced; acted on at its rising edge only.
REQ-007 SHALL have port abort  input  1  synchronous abort, level.
REQ-008 SHALL have port cond_start  output  NUM_COND  one-hot launch pulse to condition engine i.
REQ-009 SHALL have port cond_done  input  NUM_COND  completion from condition engine i.
REQ-010 SHALL have port led  output  NUM_COND  one-hot winner indication.
REQ-011 SHALL have port rgb_led  output  4  status: bit0 running, bit1 complete, bit2 timeout error, bit3 tied 0.
REQ-012 SHALL have port winner_idx  output  $clog2(NUM_COND)  winning condition index.
REQ-013 SHALL have port count_sel  input  $clog2(NUM_COND)  readback select.
REQ-014 SHALL have port count_out  output  CNT_W  stored count of condition count_sel, combinational from stored registers.

Function
REQ-015 SHALL implement FSM states IDLE, LAUNCH, WAIT, COMPARE, DONE, ERROR.
REQ-016 IDLE/DONE/ERROR: start_btn rising edge (high now, low previous cycle) SHALL clear all stored counts, led, winner_idx, set idx=0, enter LAUNCH.
REQ-017 LAUNCH SHALL last one cycle with cond_start registered so exactly bit idx is high for one cycle; cycle counter cleared to 0; next state WAIT.
REQ-018 WAIT SHALL increment counter each cycle; count = cycles from first WAIT cycle through the cycle cond_done[idx] is sampled high, inclusive (done in first WAIT cycle -> 1).
REQ-019 In WAIT, cond_done[idx] high SHALL store count for idx; if idx==NUM_COND-1 enter COMPARE, else idx+1 and LAUNCH.
REQ-020 cond_done bits other than idx, and any cond_done outside WAIT, SHALL be ignored.
REQ-021 If count reaches TIMEOUT with cond_done[idx] low, SHALL store all-ones for idx, skip remaining conditions, enter ERROR; done and timeout in the same cycle SHALL be treated as done.
REQ-022 COMPARE SHALL scan one stored count per cycle (NUM_COND cycles), strict less-than, so ties resolve to lowest index; then enter DONE.
REQ-023 DONE SHALL drive led one-hot at winner_idx, rgb_led=0010, until next start or abort.
REQ-024 ERROR SHALL drive led=0, rgb_led=0100, winner_idx=0; stored counts retained.
REQ-025 rgb_led SHALL be 0001 in LAUNCH, WAIT, COMPARE; 0000 in IDLE.
REQ-026 start_btn rising edges in LAUNCH/WAIT/COMPARE SHALL be ignored; start_btn held high SHALL not retrigger.
REQ-027 abort high in any state SHALL enter IDLE next cycle, clear led, cond_start, rgb_led; stored counts retained; abort has priority over start_btn.
REQ-028 All outputs except count_out SHALL be registered.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, idx=0, counter=0, all stored counts=0, cond_start=0, led=0, rgb_led=0000, winner_idx=0, start edge detector history=1 (no start from a button held through reset).
REQ-030 Reset assertion mid-run SHALL discard the run; no cond_start pulse after release until a new start_btn rising edge.

Verification (NUM_COND=4, CNT_W=32, TIMEOUT=1000)
REQ-031 Reset with start_btn high, release, hold high 50 cycles -> led=0000, rgb_led=0000, no cond_start pulse.
REQ-032 Engines reply done after 40,30,20,10 cycles -> counts 40,30,20,10, cond_start pulses 0001,0010,0100,1000 once each, led=1000, winner_idx=3, rgb_led=0010.
REQ-033 Latencies 15,15,20,15 -> led=0001, winner_idx=0 (tie to lowest index).
REQ-034 Condition 2 never completes -> count[2]=FFFFFFFF after 1000 WAIT cycles, no cond_start[3], rgb_led=0100, led=0000.
REQ-035 Abort on 5th WAIT cycle of condition 1, then stray cond_done=0010 -> IDLE, rgb_led=0000, count[1] unchanged 0.
REQ-036 From DONE, new start edge with latencies 5,6,7,8 -> counts cleared then 5,6,7,8, led=0001; start_btn pulse during WAIT has no effect.

Source files
------------

// File: rtl/bench_scoreboard.sv
// bench_scoreboard: launches NUM_COND condition engines one after another, times each, picks the fastest
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start_btn               run request, acted on at rising edge while IDLE/DONE/ERROR
//   abort                   synchronous abort to IDLE, priority over start
//   cond_start/cond_done    one-hot launch pulse / completion per condition engine
//   led, winner_idx         one-hot and index of the fastest condition (DONE only)
//   rgb_led                 {0, timeout error, complete, running}
//   count_sel/count_out     combinational readback of stored cycle counts
module bench_scoreboard #(
  parameter int NUM_COND = 4,
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 1048576,
  localparam int IW = $clog2(NUM_COND)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_btn,
  input  logic                abort,
  output logic [NUM_COND-1:0] cond_start,
  input  logic [NUM_COND-1:0] cond_done,
  output logic [NUM_COND-1:0] led,
  output logic [3:0]          rgb_led,
  output logic [IW-1:0]       winner_idx,
  input  logic [IW-1:0]       count_sel,
  output logic [CNT_W-1:0]    count_out
);
  localparam longint TO_L = longint'(TIMEOUT);
  localparam logic [IW-1:0] LAST = IW'(NUM_COND - 1);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  localparam logic [NUM_COND-1:0] ONE = NUM_COND'(1);
  if (NUM_COND < 2 || NUM_COND > 8) begin : g_bad_cond
    $error("NUM_COND must be 2..8");
  end
  if (TIMEOUT < 1 || (TO_L >> CNT_W) != 0) begin : g_bad_timeout
    $error("TIMEOUT must be 1..2^CNT_W-1");
  end
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, COMPARE, DONE, ERROR} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx, scan, win_nx;
  logic [CNT_W-1:0] cnt, cnt_inc, best;
  logic [CNT_W-1:0] counts [NUM_COND];
  logic start_q, start_rise, clr, hit, expire, take;
  assign start_rise = start_btn & ~start_q;
  assign clr = !abort && start_rise && (state == IDLE || state == DONE || state == ERROR);
  assign cnt_inc = cnt + CNT_W'(1);
  // done wins over a timeout landing in the same cycle
  assign hit = !abort && state == WAIT && cond_done[idx];
  assign expire = !abort && state == WAIT && !cond_done[idx] && cnt_inc == TO_C;
  // strict less-than keeps the earliest index on ties
  assign take = scan == '0 || counts[scan] < best;
  assign win_nx = take ? scan : winner_idx;
  assign count_out = (32'(count_sel) < NUM_COND) ? counts[count_sel] : '0;
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    if (abort) state_nx = IDLE;
    else case (state)
      IDLE, DONE, ERROR: if (start_rise) begin
        state_nx = LAUNCH;
        idx_nx = '0;
      end
      LAUNCH: state_nx = WAIT;
      WAIT: if (hit) begin
        state_nx = idx == LAST ? COMPARE : LAUNCH;
        idx_nx = idx == LAST ? idx : idx + IW'(1);
      end else if (expire) state_nx = ERROR;
      COMPARE: state_nx = scan == LAST ? DONE : COMPARE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      cnt <= '0;
      scan <= '0;
      best <= '0;
      start_q <= 1'b1;
      cond_start <= '0;
      led <= '0;
      rgb_led <= '0;
      winner_idx <= '0;
      for (int i = 0; i < NUM_COND; i++) counts[i] <= '0;
    end else begin
      start_q <= start_btn;
      idx <= idx_nx;
      cnt <= state == WAIT ? cnt_inc : '0;
      scan <= state == COMPARE ? scan + IW'(1) : '0;
      cond_start <= state_nx == LAUNCH ? ONE << idx_nx : '0;
      rgb_led <= {1'b0, state_nx == ERROR, state_nx == DONE,
                  state_nx == LAUNCH || state_nx == WAIT || state_nx == COMPARE};
      if (clr) begin
        for (int i = 0; i < NUM_COND; i++) counts[i] <= '0;
        led <= '0;
        winner_idx <= '0;
      end
      if (hit) counts[idx] <= cnt_inc;
      if (expire) counts[idx] <= '1;
      if (!abort && state == COMPARE && take) begin
        best <= counts[scan];
        winner_idx <= scan;
      end
      if (abort) led <= '0;
      else if (state == COMPARE && scan == LAST) led <= ONE << win_nx;
    end
endmodule

// File: tb/tb_bench_scoreboard.sv
// tb_bench_scoreboard: directed runs of bench_scoreboard with a queued-expectation scoreboard
module tb_bench_scoreboard;
  logic clk = 0, reset_n = 0, start_btn = 1, abort = 0, pulse_clr = 0;
  logic [3:0] cond_start, cond_done, led, rgb_led;
  logic [3:0] eng_done = 0, stray = 0;
  logic [1:0] winner_idx, count_sel = 0;
  logic [31:0] count_out;
  int checks = 0, failures = 0, runs_seen = 0;
  int lat [4] = '{0, 0, 0, 0};
  int pulses [4] = '{0, 0, 0, 0};
  typedef struct packed {
    logic [3:0] led;
    logic [1:0] win;
    logic [3:0] rgb;
    logic [3:0][31:0] cnt;
    logic [3:0][7:0] pul;
  } exp_t;
  exp_t exp_q [$];
  assign cond_done = eng_done | stray;
  always #5 clk = ~clk;
  bench_scoreboard #(.NUM_COND(4), .CNT_W(32), .TIMEOUT(1000)) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .abort(abort),
    .cond_start(cond_start), .cond_done(cond_done), .led(led), .rgb_led(rgb_led),
    .winner_idx(winner_idx), .count_sel(count_sel), .count_out(count_out)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic push(logic [3:0] l, logic [1:0] w, logic [3:0] r,
                      logic [31:0] c0, logic [31:0] c1, logic [31:0] c2, logic [31:0] c3,
                      logic [7:0] p0, logic [7:0] p1, logic [7:0] p2, logic [7:0] p3);
    exp_t e;
    e.led = l; e.win = w; e.rgb = r;
    e.cnt[0] = c0; e.cnt[1] = c1; e.cnt[2] = c2; e.cnt[3] = c3;
    e.pul[0] = p0; e.pul[1] = p1; e.pul[2] = p2; e.pul[3] = p3;
    exp_q.push_back(e);
  endtask
  task automatic run_start();
    @(posedge clk); #1 pulse_clr = 1; start_btn = 1;
    @(posedge clk); #1 pulse_clr = 0;
    @(posedge clk); #1 start_btn = 0;
  endtask
  task automatic wait_runs(int n);
    for (int k = 0; k < 3000 && runs_seen < n; k++) @(posedge clk);
    checks++;
    if (runs_seen < n) begin
      failures++;
      $display("FAIL run_timeout actual=%0d required=%0d", runs_seen, n);
    end
  endtask
  always @(negedge clk)
    for (int i = 0; i < 4; i++) pulses[i] <= pulse_clr ? 0 : pulses[i] + int'(cond_start[i]);
  // condition engines: raise done so it is sampled on the lat-th WAIT cycle; lat 0 never answers
  initial forever begin
    int i;
    @(negedge clk);
    if (reset_n && cond_start != 0) begin
      i = cond_start[3] ? 3 : cond_start[2] ? 2 : cond_start[1] ? 1 : 0;
      if (lat[i] > 0) begin
        repeat (lat[i]) @(posedge clk);
        #1 eng_done[i] = 1;
        @(posedge clk);
        #1 eng_done[i] = 0;
      end
    end
  end
  // monitor: a run ends on entry to DONE/ERROR or on abort back to idle
  initial begin
    logic [3:0] prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (reset_n && rgb_led != prev &&
          (rgb_led == 4'b0010 || rgb_led == 4'b0100 || (rgb_led == 4'b0000 && prev == 4'b0001))) begin
        repeat (3) @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result rgb_led=%b", rgb_led);
        end else begin
          e = exp_q.pop_front();
          chk("led", 32'(led), 32'(e.led));
          chk("winner_idx", 32'(winner_idx), 32'(e.win));
          chk("rgb_led", 32'(rgb_led), 32'(e.rgb));
          for (int i = 0; i < 4; i++) begin
            count_sel = 2'(i);
            #1 chk($sformatf("count[%0d]", i), count_out, e.cnt[i]);
            chk($sformatf("start_pulses[%0d]", i), 32'(pulses[i]), 32'(e.pul[i]));
          end
          count_sel = 0;
        end
        runs_seen++;
      end
      prev = rgb_led;
    end
  end
  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(led), 0);
    chk("reset_rgb", 32'(rgb_led), 0);
    chk("reset_winner", 32'(winner_idx), 0);
    chk("reset_cond_start", 32'(cond_start), 0);
    chk("reset_count0", count_out, 0);
    @(posedge clk); #1 reset_n = 1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("held_led", 32'(led), 0);
    chk("held_rgb", 32'(rgb_led), 0);
    chk("held_pulses", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 0);
    @(posedge clk); #1 start_btn = 0;
    repeat (2) @(posedge clk);
    lat = '{40, 30, 20, 10};
    push(4'b1000, 2'd3, 4'b0010, 40, 30, 20, 10, 1, 1, 1, 1);
    run_start();
    wait_runs(1);
    lat = '{15, 15, 20, 15};
    push(4'b0001, 2'd0, 4'b0010, 15, 15, 20, 15, 1, 1, 1, 1);
    run_start();
    wait_runs(2);
    lat = '{5, 6, 7, 8};
    push(4'b0001, 2'd0, 4'b0010, 5, 6, 7, 8, 1, 1, 1, 1);
    run_start();
    @(posedge clk); #1 start_btn = 1;
    @(posedge clk); #1 start_btn = 0;
    wait_runs(3);
    lat = '{50, 60, 0, 70};
    push(4'b0000, 2'd0, 4'b0100, 50, 60, 32'hFFFF_FFFF, 0, 1, 1, 1, 0);
    run_start();
    wait_runs(4);
    lat = '{10, 20, 0, 0};
    push(4'b0000, 2'd0, 4'b0000, 10, 0, 0, 0, 1, 1, 0, 0);
    run_start();
    for (k = 0; k < 200 && !cond_start[1]; k++) @(negedge clk);
    chk("launch1_seen", 32'(cond_start[1]), 1);
    repeat (5) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0; stray = 4'b0010;
    repeat (2) @(posedge clk);
    #1 stray = 0;
    wait_runs(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
